// File: rtl/matmul_job_arbiter_pkg.sv
// Shared types and constants for the matmul job arbiter: FSM state encoding,
// default array geometry, operand-width helper and fp16 reference constants.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_RESP
    } state_t;

    localparam int DEF_W = 16;
    localparam int DEF_N = 3;

    localparam logic [15:0] FP16_ONE   = 16'h3c00;
    localparam logic [15:0] FP16_THREE = 16'h4200;

    // Bit width of one packed N x N matrix of W-bit elements.
    function automatic int mat_width(input int w, input int n);
        return w * n * n;
    endfunction

endpackage

// File: rtl/matmul_job_arbiter_if.sv
// Bundle of requester, response and array-side signals around the matmul job
// arbiter; the slave modport is the arbiter's view, master is the environment's.
interface matmul_job_arbiter_if
    import matmul_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int N    = DEF_N,
    parameter int NREQ = 2
);
    localparam int MAT = mat_width(W, N);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]     i_req_valid;
    logic [NREQ-1:0]     o_req_ready;
    logic [NREQ*MAT-1:0] i_req_A;
    logic [NREQ*MAT-1:0] i_req_B;
    logic [NREQ-1:0]     i_req_mode;
    logic [NREQ-1:0]     o_rsp_valid;
    logic [NREQ-1:0]     i_rsp_ready;
    logic [MAT-1:0]      o_rsp_C;
    logic                o_rsp_err;
    logic                o_mm_rst;
    logic                o_mm_en;
    logic                o_mm_mode;
    logic [MAT-1:0]      o_mm_A;
    logic [MAT-1:0]      o_mm_B;
    logic [MAT-1:0]      i_mm_C;
    logic                i_mm_done;
    logic                o_busy;
    logic [IDW-1:0]      o_grant_id;

    modport slave (
        input  i_req_valid, i_req_A, i_req_B, i_req_mode, i_rsp_ready, i_mm_C, i_mm_done,
        output o_req_ready, o_rsp_valid, o_rsp_C, o_rsp_err, o_mm_rst, o_mm_en, o_mm_mode,
               o_mm_A, o_mm_B, o_busy, o_grant_id
    );

    modport master (
        output i_req_valid, i_req_A, i_req_B, i_req_mode, i_rsp_ready, i_mm_C, i_mm_done,
        input  o_req_ready, o_rsp_valid, o_rsp_C, o_rsp_err, o_mm_rst, o_mm_en, o_mm_mode,
               o_mm_A, o_mm_B, o_busy, o_grant_id
    );

endinterface

// File: rtl/matmul_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester set at or after last+1,
// wrapping, returned both as a one-hot grant and as an encoded index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last) + off) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Shares one systolic matmul unit between NREQ requesters: round-robin accept,
// array clear, run until done, then a per-owner response. Optional RUN-state
// timeout is enabled by defining MATMUL_ARB_TIMEOUT_EN.
module matmul_job_arbiter
    import matmul_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int N          = DEF_N,
    parameter int NREQ       = 2,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input logic                 i_clk,
    input logic                 i_rst,
    matmul_job_arbiter_if.slave bus
);

    localparam int MAT = mat_width(W, N);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(CLR_CYCLES + 1);

    state_t         state, state_next;
    logic [CW-1:0]  clr_cnt;
    logic [IDW-1:0] last, grant_id, win_id;
    logic [NREQ-1:0] win;
    logic [MAT-1:0] a_reg, b_reg, c_reg, sel_a, sel_b;
    logic           mode_reg, sel_mode;
    logic           accept, done_take;

`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]  run_cnt;
    logic           timeout_hit;
    logic           err_reg;
`else
    logic [31:0]    unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_arb (
        .req     (bus.i_req_valid),
        .last    (last),
        .grant   (win),
        .grant_id(win_id)
    );

    // Pick the winner's operand slice so it can be latched on the accept edge.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_mode = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (win[k]) begin
                sel_a    = bus.i_req_A[k*MAT +: MAT];
                sel_b    = bus.i_req_B[k*MAT +: MAT];
                sel_mode = bus.i_req_mode[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        accept          = 1'b0;
        done_take       = 1'b0;
        bus.o_req_ready = '0;
        bus.o_mm_en     = 1'b0;
        bus.o_rsp_valid = '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
        timeout_hit     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                bus.o_req_ready = win;
                accept          = |win;
                if (accept) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_cnt == CW'(CLR_CYCLES - 1)) state_next = ST_RUN;
            end
            ST_RUN: begin
                bus.o_mm_en = 1'b1;
                // Done takes priority over a timeout landing on the same cycle.
                if (bus.i_mm_done) begin
                    done_take  = 1'b1;
                    state_next = ST_RESP;
                end
`ifdef MATMUL_ARB_TIMEOUT_EN
                else if (run_cnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                bus.o_rsp_valid[grant_id] = 1'b1;
                if (bus.i_rsp_ready[grant_id]) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (i_rst) begin
            accept          = 1'b0;
            bus.o_req_ready = '0;
            bus.o_mm_en     = 1'b0;
            bus.o_rsp_valid = '0;
        end
    end

    // Job registers: operands and owner on accept, result on done/timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= 1'b0;
            c_reg    <= '0;
            grant_id <= '0;
            last     <= IDW'(NREQ - 1);
            clr_cnt  <= '0;
        end else begin
            if (accept) begin
                a_reg    <= sel_a;
                b_reg    <= sel_b;
                mode_reg <= sel_mode;
                grant_id <= win_id;
                last     <= win_id;
            end
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + CW'(1);
            else                   clr_cnt <= '0;
            if (done_take) c_reg <= bus.i_mm_C;
`ifdef MATMUL_ARB_TIMEOUT_EN
            else if (timeout_hit) c_reg <= '0;
`endif
        end
    end

`ifdef MATMUL_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_cnt <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state == ST_RUN) run_cnt <= run_cnt + TW'(1);
            else                 run_cnt <= '0;
            if (done_take)        err_reg <= 1'b0;
            else if (timeout_hit) err_reg <= 1'b1;
        end
    end
    assign bus.o_rsp_err = err_reg;
`else
    assign bus.o_rsp_err = 1'b0;
`endif

    assign bus.o_mm_rst   = i_rst | (state == ST_CLEAR);
    assign bus.o_mm_mode  = mode_reg;
    assign bus.o_mm_A     = a_reg;
    assign bus.o_mm_B     = b_reg;
    assign bus.o_rsp_C    = c_reg;
    assign bus.o_busy     = (state != ST_IDLE);
    assign bus.o_grant_id = grant_id;

endmodule

// File: doc/matmul_job_arbiter.md
# matmul_job_arbiter

Shares one `control` matrix-multiply unit (N×N systolic array, W-bit fp16 elements) between NREQ independent requesters. It arbitrates round-robin, latches the winning operand pair, and pulses the array reset. It then drives enable until the array reports done, captures the result, and returns it to the owning requester over a valid/ready response channel. It sits directly above `control` and is the only block that drives that unit's reset and enable inputs.

## Interface
Parameters:
- `W`, 16, element width (fp16)
- `N`, 3, matrix dimension
- `NREQ`, 2, number of requesters (2..8)
- `CLR_CYCLES`, 2, array-reset cycles before each job (≥1)
- `TIMEOUT`, 64, RUN-state cycle limit (used only with the timeout macro)

Ports (`MAT = W*N*N`):
- `i_clk` in 1: clock
- `i_rst` in 1: synchronous, active-high reset
- `i_req_valid` in NREQ: per-requester job valid
- `o_req_ready` out NREQ: one-hot accept
- `i_req_A`, `i_req_B` in NREQ*MAT: operands; requester k occupies slice [k*MAT +: MAT]
- `i_req_mode` in NREQ: per-requester mode bit
- `o_rsp_valid` out NREQ: one-hot response valid
- `i_rsp_ready` in NREQ: per-requester response ready
- `o_rsp_C` out MAT: result, qualified by `o_rsp_valid`
- `o_rsp_err` out 1: job aborted by timeout, qualified by `o_rsp_valid`
- `o_mm_rst`, `o_mm_en`, `o_mm_mode` out 1: to `control`
- `o_mm_A`, `o_mm_B` out MAT: to `control`
- `i_mm_C` in MAT, `i_mm_done` in 1: from `control`
- `o_busy` out 1: state ≠ IDLE
- `o_grant_id` out clog2(NREQ): owner of the current job

## Operation
- FSM: IDLE → CLEAR → RUN → RESP → IDLE.
- IDLE:
  - The winner is the first requester with valid set, searching from `last+1` and wrapping.
  - `o_req_ready` is the one-hot of the winner, driven combinationally from `i_req_valid`, and is 0 in all other states.
  - On handshake: latch A, B, mode and the winner id; set `last` = winner; go to CLEAR.
  - A requester may drop valid before its handshake; arbitration re-evaluates every cycle.
- CLEAR: `o_mm_rst`=1 and `o_mm_en`=0 for exactly CLR_CYCLES cycles, then RUN.
- RUN:
  - `o_mm_en`=1.
  - When `i_mm_done`=1 is sampled, capture `i_mm_C` into the result register, set err=0, go to RESP.
  - `i_mm_done` is ignored in every other state.
- RESP:
  - `o_rsp_valid[grant]`=1 with C and err held stable until `i_rsp_ready[grant]`=1.
  - The cycle after that handshake the FSM is in IDLE.
  - The ready bits of non-owners are ignored.
- `o_mm_A`, `o_mm_B`, `o_mm_mode` present the latched registers and stay stable from CLEAR through RESP.
- `o_mm_rst` = `i_rst` OR (state==CLEAR). The array is held in reset throughout block reset.
- Reset mid-job: the job is dropped without a response, FSM → IDLE, and `last` = NREQ-1, so requester 0 has first priority.
- Reset values: all outputs 0 except `o_mm_rst`=1 while `i_rst` is high. Result, operand and grant registers reset to 0.

## Timing
- Handshake cycle t (IDLE).
- Cycles t+1 .. t+CLR_CYCLES: CLEAR.
- `o_mm_en` rises at t+CLR_CYCLES+1.
- If done is sampled at cycle d, `o_rsp_valid` rises at d+1 and `o_mm_en`=0 from d+1.
- Earliest next accept is the cycle after the response handshake, i.e. a one-cycle IDLE gap minimum.
- Done coincident with the first RUN cycle is legal: the response follows one cycle later.

## Configuration
- `MATMUL_ARB_TIMEOUT_EN` defined:
  - A RUN cycle counter is cleared on entry to RUN.
  - If it reaches TIMEOUT with no done, go to RESP with `o_rsp_C`=0 and `o_rsp_err`=1.
  - The next job's CLEAR recovers the array.
  - Done and the final timeout cycle arriving together: done wins, err=0.
- Undefined: no counter, `o_rsp_err` tied 0, RUN waits indefinitely, TIMEOUT unused.

## Structure
- Package `matmul_pkg`:
  - state enum (IDLE, CLEAR, RUN, RESP)
  - default W/N
  - MAT width function
  - fp16 constants ONE=16'h3c00, THREE=16'h4200
- Sub-module `rr_arbiter` (NREQ, req vector, last pointer → one-hot grant and encoded id), purely combinational.

## Test plan
Bench model of `control`: done 12 cycles after `o_mm_en` rises; C = A·B for the operands used.
- **Single job:** requester 0, A=B=all 16'h3c00 → CLEAR 2 cycles, en 12 cycles, `o_rsp_valid`=2'b01, C all 16'h4200, err 0.
- **Contention:** both valid from reset → grant order 0,1,0,1 across 4 jobs; each response goes only to its owner.
- **Backpressure:** hold `i_rsp_ready`=0 for 10 cycles → C/valid stable, no new accept, `o_mm_en`=0.
- **Reset in RUN:** assert `i_rst` mid-job → no response; `o_mm_rst`=1; next job granted to requester 0.
- **Stray done:** pulse `i_mm_done` in IDLE and CLEAR → no state change.
- **Timeout (macro on, TIMEOUT=8, model never done):** after 8 RUN cycles response has err=1, C=0; the following job completes normally.
